// File: rtl/size_exploration_pkg.sv
// Shared definitions for the size-exploration result serializer.
// Contents:
//   state_e      - serializer FSM states, 2-bit encoding
//   LAT_CNT_W    - latency counter width (holds 0..15)
//   bit_cnt_w()  - bit counter width for a given word width
//   parity_even()- parity bit that makes the total count of ones even
package size_exploration_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SHIFT  = 2'd2,
        PARITY = 2'd3
    } state_e;

    localparam int LAT_CNT_W = 4;

    // Width of the bit counter; never below one bit.
    function automatic int bit_cnt_w(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

    // XOR-reduce of the word (zero-extended by the caller); appending this bit
    // makes the total number of ones even.
    function automatic logic parity_even(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/size_exploration_down_counter.sv
// Loadable down-counter with enable and zero flag.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset, clears the count
//   i_ena      in   global enable; low holds the count
//   i_load     in   load i_load_val (has priority over i_dec)
//   i_dec      in   decrement by one, saturating at zero
//   i_load_val in   value to load
//   o_count    out  current count
//   o_zero     out  count equals zero
module size_exploration_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ena,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load, decrement or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_ena) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != {W{1'b0}})) begin
                r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == {W{1'b0}});

endmodule

// File: rtl/size_exploration_result_serializer.sv
// Captures the result word LATENCY cycles after an accepted start and
// shifts it out MSB-first on one serial line, followed by an even-parity bit.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset; aborts any frame in flight
//   ena       in   global enable; low freezes all state and outputs
//   start     in   frame request, sampled in IDLE only
//   result    in   result bus from the module under exploration
//   ser_out   out  serial data (data bits, then parity)
//   ser_valid out  high while ser_out carries a data or parity bit
//   busy      out  high from the cycle after start through the parity bit
//   done      out  one-cycle pulse after the parity bit
module size_exploration_result_serializer
    import size_exploration_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] result,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int BCW = bit_cnt_w(WIDTH);
    localparam logic [BCW-1:0]       BIT_LOAD = BCW'(WIDTH - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = 4'd1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic             r_parity;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_capture;
    logic             w_shift_adv;
    logic             w_lat_load;
    logic             w_lat_dec;
    logic             w_bit_dec;
    logic             w_ser_out_nxt;
    logic             w_ser_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [LAT_CNT_W-1:0] w_lat_cnt;
    logic                 w_lat_zero;
    logic [BCW-1:0]       w_bit_cnt;
    logic                 w_bit_zero;

    // Latency counter: loaded on start, capture happens on the edge it reaches zero.
    size_exploration_down_counter #(.W(LAT_CNT_W)) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ena      (ena),
        .i_load     (w_lat_load),
        .i_dec      (w_lat_dec),
        .i_load_val (LAT_LOAD),
        .o_count    (w_lat_cnt),
        .o_zero     (w_lat_zero)
    );

    // Bit counter: holds the number of data bits still to follow the one on the line.
    size_exploration_down_counter #(.W(BCW)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ena      (ena),
        .i_load     (w_capture),
        .i_dec      (w_bit_dec),
        .i_load_val (BIT_LOAD),
        .o_count    (w_bit_cnt),
        .o_zero     (w_bit_zero)
    );

    // Next-state and next-output logic; outputs are computed one edge ahead
    // so every port comes straight from a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        w_shift_adv     = 1'b0;
        w_lat_load      = 1'b0;
        w_lat_dec       = 1'b0;
        w_bit_dec       = 1'b0;
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (LATENCY == 0) begin
                        w_capture       = 1'b1;
                        w_state_nxt     = SHIFT;
                        w_ser_out_nxt   = result[WIDTH-1];
                        w_ser_valid_nxt = 1'b1;
                    end else begin
                        w_lat_load  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_busy_nxt = 1'b1;
                w_lat_dec  = 1'b1;
                // Count of one means this edge takes it to zero: capture now.
                if (w_lat_cnt == LAT_ONE) begin
                    w_capture       = 1'b1;
                    w_state_nxt     = SHIFT;
                    w_ser_out_nxt   = result[WIDTH-1];
                    w_ser_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            SHIFT: begin
                w_busy_nxt      = 1'b1;
                w_ser_valid_nxt = 1'b1;
                if (w_bit_zero) begin
                    w_state_nxt   = PARITY;
                    w_ser_out_nxt = r_parity;
                end else begin
                    w_bit_dec     = 1'b1;
                    w_shift_adv   = 1'b1;
                    w_ser_out_nxt = r_shift[WIDTH-2];
                end
            end
            PARITY: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, shift register, parity and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= {WIDTH{1'b0}};
            r_parity    <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (ena) begin
            r_state     <= w_state_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            if (w_capture) begin
                r_shift  <= result;
                r_parity <= parity_even(32'(result));
            end else if (w_shift_adv) begin
                r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                r_parity <= r_parity;
            end else begin
                r_shift  <= r_shift;
                r_parity <= r_parity;
            end
        end else begin
            r_state     <= r_state;
            r_shift     <= r_shift;
            r_parity    <= r_parity;
            r_ser_out   <= r_ser_out;
            r_ser_valid <= r_ser_valid;
            r_busy      <= r_busy;
            r_done      <= r_done;
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_size_exploration_result_serializer.sv
// Directed testbench for size_exploration_result_serializer.
// dut_a: WIDTH=32 LATENCY=0, dut_b: WIDTH=32 LATENCY=2, dut_c: WIDTH=20 LATENCY=0.
module tb_size_exploration_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start_a, start_b, start_c;
    logic [31:0] result_a, result_b;
    logic [19:0] result_c;
    logic        so_a, sv_a, busy_a, done_a;
    logic        so_b, sv_b, busy_b, done_b;
    logic        so_c, sv_c, busy_c, done_c;

    int checks;
    int errors;

    size_exploration_result_serializer #(.WIDTH(32), .LATENCY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_a), .result(result_a),
        .ser_out(so_a), .ser_valid(sv_a), .busy(busy_a), .done(done_a)
    );

    size_exploration_result_serializer #(.WIDTH(32), .LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .result(result_b),
        .ser_out(so_b), .ser_valid(sv_b), .busy(busy_b), .done(done_b)
    );

    size_exploration_result_serializer #(.WIDTH(20), .LATENCY(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_c), .result(result_c),
        .ser_out(so_c), .ser_valid(sv_c), .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are then sampled and inputs driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start_a = 1'b1;
        rst_n   = 1'b0;
        step();
        checks++;
        if ({so_a, sv_a, busy_a, done_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got out/valid/busy/done=%b required 0000",
                     {so_a, sv_a, busy_a, done_a});
        end
        start_a = 1'b0;
        rst_n   = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        logic [31:0] w;
        int          busy_cnt;
        w        = 32'hA5A50001;
        result_a = w;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        result_a = 32'h0;
        busy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sv_a !== 1'b1 || so_a !== w[31-i]) begin
                errors++;
                $display("FAIL basic_bit%0d: valid=%b out=%b required valid=1 out=%b",
                         i, sv_a, so_a, w[31-i]);
            end
            if (busy_a === 1'b1) busy_cnt++;
            step();
        end
        checks++;
        if (sv_a !== 1'b1 || so_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_parity: valid=%b out=%b done=%b required 1 1 0", sv_a, so_a, done_a);
        end
        if (busy_a === 1'b1) busy_cnt++;
        step();
        checks++;
        if (done_a !== 1'b1 || sv_a !== 1'b0 || so_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b out=%b busy=%b required 1 0 0 0",
                     done_a, sv_a, so_a, busy_a);
        end
        step();
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b required 0", done_a);
        end
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d cycles required 33", busy_cnt);
        end
    endtask

    task automatic test_latency();
        result_b = 32'h0;
        start_b  = 1'b1;
        step();
        start_b  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sv_b !== 1'b0 || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL lat_wait%0d: valid=%b busy=%b required valid=0 busy=1", i, sv_b, busy_b);
            end
            if (i == 1) result_b = 32'h80000000;
            step();
        end
        result_b = 32'hFFFFFFFF;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sv_b !== 1'b1 || so_b !== (i == 0)) begin
                errors++;
                $display("FAIL lat_bit%0d: valid=%b out=%b required valid=1 out=%b",
                         i, sv_b, so_b, (i == 0));
            end
            step();
        end
        checks++;
        if (sv_b !== 1'b1 || so_b !== 1'b1) begin
            errors++;
            $display("FAIL lat_parity: valid=%b out=%b required 1 1", sv_b, so_b);
        end
        step();
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL lat_done: done=%b busy=%b required 1 0", done_b, busy_b);
        end
        step();
    endtask

    task automatic test_enable();
        logic [31:0] w;
        // start during ena=0 must not be queued
        ena     = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        ena     = 1'b1;
        step();
        checks++;
        if (busy_a !== 1'b0 || sv_a !== 1'b0) begin
            errors++;
            $display("FAIL ena_start_ignored: busy=%b valid=%b required 0 0", busy_a, sv_a);
        end
        w        = 32'h12345678;
        result_a = w;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sv_a !== 1'b1 || so_a !== w[31-i]) begin
                errors++;
                $display("FAIL ena_bit%0d: valid=%b out=%b required valid=1 out=%b",
                         i, sv_a, so_a, w[31-i]);
            end
            if (i == 10) begin
                ena = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    step();
                    checks++;
                    if (sv_a !== 1'b1 || so_a !== w[21] || busy_a !== 1'b1 || done_a !== 1'b0) begin
                        errors++;
                        $display("FAIL ena_frozen%0d: valid=%b out=%b busy=%b done=%b required 1 %b 1 0",
                                 j, sv_a, so_a, busy_a, done_a, w[21]);
                    end
                end
                ena = 1'b1;
            end
            step();
        end
        checks++;
        if (sv_a !== 1'b1 || so_a !== 1'b1) begin
            errors++;
            $display("FAIL ena_parity: valid=%b out=%b required 1 1", sv_a, so_a);
        end
        step();
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL ena_done: done=%b required 1", done_a);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        result_a = 32'hDEADBEEF;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({so_a, sv_a, busy_a, done_a} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs: got out/valid/busy/done=%b required 0000",
                     {so_a, sv_a, busy_a, done_a});
        end
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (done_a !== 1'b0 || sv_a !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet%0d: done=%b valid=%b required 0 0", i, done_a, sv_a);
            end
        end
        w        = 32'h0F0F0F0F;
        result_a = w;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sv_a !== 1'b1 || so_a !== w[31-i]) begin
                errors++;
                $display("FAIL midrst_bit%0d: valid=%b out=%b required valid=1 out=%b",
                         i, sv_a, so_a, w[31-i]);
            end
            step();
        end
        checks++;
        if (sv_a !== 1'b1 || so_a !== 1'b0) begin
            errors++;
            $display("FAIL midrst_parity: valid=%b out=%b required 1 0", sv_a, so_a);
        end
        step();
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_done: done=%b required 1", done_a);
        end
        step();
    endtask

    task automatic test_back_to_back();
        result_a = 32'h0000000F;
        start_a  = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (sv_a !== 1'b1 || so_a !== (i >= 28) || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_f%0d_bit%0d: valid=%b out=%b busy=%b required 1 %b 1",
                             f, i, sv_a, so_a, busy_a, (i >= 28));
                end
                step();
            end
            checks++;
            if (sv_a !== 1'b1 || so_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_f%0d_parity: valid=%b out=%b required 1 0", f, sv_a, so_a);
            end
            step();
            checks++;
            if (done_a !== 1'b1 || sv_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_f%0d_idle: done=%b valid=%b busy=%b required 1 0 0",
                         f, done_a, sv_a, busy_a);
            end
            if (f == 1) start_a = 1'b0;
            step();
        end
        checks++;
        if (sv_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: valid=%b busy=%b required 0 0", sv_a, busy_a);
        end
    endtask

    task automatic test_width20();
        result_c = 20'hFFFFF;
        start_c  = 1'b1;
        step();
        start_c  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sv_c !== 1'b1 || so_c !== 1'b1) begin
                errors++;
                $display("FAIL w20_bit%0d: valid=%b out=%b required 1 1", i, sv_c, so_c);
            end
            step();
        end
        checks++;
        if (sv_c !== 1'b1 || so_c !== 1'b0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL w20_parity: valid=%b out=%b done=%b required 1 0 0", sv_c, so_c, done_c);
        end
        step();
        checks++;
        if (done_c !== 1'b1 || sv_c !== 1'b0 || busy_c !== 1'b0) begin
            errors++;
            $display("FAIL w20_done: done=%b valid=%b busy=%b required 1 0 0", done_c, sv_c, busy_c);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        result_a = 32'h0;
        result_b = 32'h0;
        result_c = 20'h0;
        step();
        test_reset();
        do_reset();
        test_basic_frame();
        do_reset();
        test_latency();
        do_reset();
        test_enable();
        do_reset();
        test_reset_mid_frame();
        do_reset();
        test_back_to_back();
        do_reset();
        test_width20();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
